pong_tick_sched: RTL

Timing scheduler for the ping-pong game. A single clock prescaler produces a 1 ms base tick. From that tick, the block sequences the game-phase timers (serve delay, post-point pause) and issues single-cycle step enables to the ball and paddle movement logic. Ball speed rises with the paddle-hit count. It sits between the system clock and the game datapath and replaces ad-hoc per-module dividers.

---
 rtl/pong_timing_pkg.sv | 33 +++
 rtl/pong_tick_sched_if.sv | 31 +++
 rtl/ms_prescaler.sv | 39 +++
 rtl/pong_tick_sched.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pong_timing_pkg.sv
// ---------------------------------------------------------------------------
// pong_timing_pkg
// Shared types and helpers for the ping-pong timing scheduler.
//   phase_e     : game phase encoding (IDLE/SERVE/PLAY/POINT), 2 bits
//   level_t     : ball speed level, 0..LEVEL_MAX
//   cnt_w()     : counter width for a counter that runs 0..n-1
//   ball_period : ms between ball steps at a given speed level
// ---------------------------------------------------------------------------
package pong_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    POINT = 2'd3
  } phase_e;

  localparam int LEVEL_W = 2;
  typedef logic [LEVEL_W-1:0] level_t;
  localparam level_t LEVEL_MAX = '1;

  // A counter that wraps at n-1 needs $clog2(n) bits; never fewer than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned ball_period(input level_t level,
                                              input int unsigned ms0,
                                              input int unsigned step);
    return ms0 - step * 32'(level);
  endfunction

endpackage

// File: rtl/pong_tick_sched_if.sv
// ---------------------------------------------------------------------------
// pong_tick_sched_if
// Control/status bundle between the game datapath and the tick scheduler.
//   start, pause, paddle_hit, point_scored : game -> scheduler
//   ms_tick, ball_step, paddle_step        : one-cycle pulses, scheduler -> game
//   state, speed_level                     : current phase and ball speed level
// master = game side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface pong_tick_sched_if;

  logic                    start;
  logic                    pause;
  logic                    paddle_hit;
  logic                    point_scored;
  logic                    ms_tick;
  logic                    ball_step;
  logic                    paddle_step;
  logic [1:0]              state;
  pong_timing_pkg::level_t speed_level;

  modport master (
    output start, pause, paddle_hit, point_scored,
    input  ms_tick, ball_step, paddle_step, state, speed_level
  );

  modport slave (
    input  start, pause, paddle_hit, point_scored,
    output ms_tick, ball_step, paddle_step, state, speed_level
  );

endinterface

// File: rtl/ms_prescaler.sv
// ---------------------------------------------------------------------------
// ms_prescaler
// Free-running divider: counts 0..BASE_DIV-1 and emits a registered one-cycle
// ms_tick in the cycle after the count reaches BASE_DIV-1.
//   clk     : system clock
//   reset   : asynchronous, active-low
//   ms_tick : one-cycle pulse every BASE_DIV cycles
// ---------------------------------------------------------------------------
module ms_prescaler #(
  parameter int unsigned BASE_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic ms_tick
);
  import pong_timing_pkg::*;

  localparam int unsigned      CNT_W    = cnt_w(BASE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BASE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // NOTE: clocked state is written with <= so every register samples the
  // pre-edge values; blocking writes here would chain r_cnt into r_tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == CNT_LAST);
      r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
    end
  end

  assign ms_tick = r_tick;

endmodule

// File: rtl/pong_tick_sched.sv
// ---------------------------------------------------------------------------
// pong_tick_sched
// Game timing scheduler: derives a 1 ms tick, sequences the SERVE/PLAY/POINT
// phase timers and issues one-cycle ball/paddle step enables. The ball speeds
// up one level every HITS_PER_LEVEL paddle hits, saturating at level 3.
//   clk   : system clock
//   reset : asynchronous, active-low
//   bus   : pong_tick_sched_if.slave (inputs start/pause/paddle_hit/
//           point_scored; outputs ms_tick/ball_step/paddle_step/state/
//           speed_level)
// Timers only advance on ms_tick cycles with pause low; the prescaler keeps
// running while paused, and event inputs are still acted on.
// ---------------------------------------------------------------------------
module pong_tick_sched #(
  parameter int unsigned BASE_DIV       = 100000,
  parameter int unsigned SERVE_MS       = 1000,
  parameter int unsigned POINT_MS       = 2000,
  parameter int unsigned PADDLE_MS      = 5,
  parameter int unsigned MOVE_MS0       = 20,
  parameter int unsigned MOVE_MS_STEP   = 4,
  parameter int unsigned HITS_PER_LEVEL = 4
) (
  input  logic               clk,
  input  logic               reset,
  pong_tick_sched_if.slave   bus
);
  import pong_timing_pkg::*;

  localparam int unsigned PHASE_MAX = (SERVE_MS > POINT_MS) ? SERVE_MS : POINT_MS;
  localparam int unsigned PHASE_W   = cnt_w(PHASE_MAX);
  localparam int unsigned PAD_W     = cnt_w(PADDLE_MS);
  localparam int unsigned BALL_W    = cnt_w(MOVE_MS0);
  localparam int unsigned HIT_W     = cnt_w(HITS_PER_LEVEL);

  localparam logic [PHASE_W-1:0] SERVE_LAST = PHASE_W'(SERVE_MS - 1);
  localparam logic [PHASE_W-1:0] POINT_LAST = PHASE_W'(POINT_MS - 1);
  localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
  localparam logic [PAD_W-1:0]   PAD_LAST   = PAD_W'(PADDLE_MS - 1);
  localparam logic [PAD_W-1:0]   PAD_ONE    = PAD_W'(1);
  localparam logic [BALL_W-1:0]  BALL_ONE   = BALL_W'(1);
  localparam logic [HIT_W-1:0]   HIT_LAST   = HIT_W'(HITS_PER_LEVEL - 1);
  localparam logic [HIT_W-1:0]   HIT_ONE    = HIT_W'(1);

  phase_e              r_state;
  logic [PHASE_W-1:0]  r_phase_cnt;
  logic [PAD_W-1:0]    r_pad_cnt;
  logic [BALL_W-1:0]   r_ball_cnt;
  logic [HIT_W-1:0]    r_hit_cnt;
  level_t              r_level;
  logic                r_ball_step;
  logic                r_paddle_step;

  logic                w_ms_tick;
  logic                w_adv;
  logic                w_pad_run;
  logic [31:0]         w_ball_last;
  logic                w_ball_due;

  ms_prescaler #(.BASE_DIV(BASE_DIV)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .ms_tick (w_ms_tick)
  );

  assign w_adv = w_ms_tick & ~bus.pause;

  // A point ends movement in the same cycle, so no step is issued alongside it.
  assign w_pad_run = w_adv &&
                     ((r_state == SERVE) || ((r_state == PLAY) && !bus.point_scored));

  // ">=" rather than "==": when a level-up shortens the period below the
  // current count, the ball steps on the very next advance instead of wrapping.
  assign w_ball_last = ball_period(r_level, MOVE_MS0, MOVE_MS_STEP) - 32'd1;
  assign w_ball_due  = (32'(r_ball_cnt) >= w_ball_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_phase_cnt   <= '0;
      r_pad_cnt     <= '0;
      r_ball_cnt    <= '0;
      r_hit_cnt     <= '0;
      r_level       <= '0;
      r_ball_step   <= 1'b0;
      r_paddle_step <= 1'b0;
    end else begin
      // NOTE: pulses default low at the top of the clocked block; a later
      // assignment in the same edge overrides it, giving exactly one-cycle highs.
      r_ball_step   <= 1'b0;
      r_paddle_step <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state     <= SERVE;
            r_phase_cnt <= '0;
            r_pad_cnt   <= '0;
            r_level     <= '0;
            r_hit_cnt   <= '0;
          end
        end

        SERVE: begin
          if (w_adv) begin
            if (r_phase_cnt == SERVE_LAST) begin
              r_state     <= PLAY;
              r_phase_cnt <= '0;
              r_ball_cnt  <= '0;
            end else begin
              r_phase_cnt <= r_phase_cnt + PHASE_ONE;
            end
          end
        end

        PLAY: begin
          if (bus.point_scored) begin
            // A coincident paddle_hit is dropped: the point wins.
            r_state     <= POINT;
            r_phase_cnt <= '0;
          end else begin
            if (bus.paddle_hit) begin
              if (r_hit_cnt == HIT_LAST) begin
                r_hit_cnt <= '0;
                if (r_level != LEVEL_MAX) r_level <= r_level + level_t'(1);
              end else begin
                r_hit_cnt <= r_hit_cnt + HIT_ONE;
              end
            end
            if (w_adv) begin
              if (w_ball_due) begin
                r_ball_step <= 1'b1;
                r_ball_cnt  <= '0;
              end else begin
                r_ball_cnt  <= r_ball_cnt + BALL_ONE;
              end
            end
          end
        end

        POINT: begin
          if (w_adv) begin
            if (r_phase_cnt == POINT_LAST) begin
              r_state     <= SERVE;
              r_phase_cnt <= '0;
              r_pad_cnt   <= '0;
              r_level     <= '0;
              r_hit_cnt   <= '0;
            end else begin
              r_phase_cnt <= r_phase_cnt + PHASE_ONE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase

      // Paddle cadence is shared by SERVE and PLAY; entries into SERVE above
      // clear the count from states where this never runs.
      if (w_pad_run) begin
        if (r_pad_cnt == PAD_LAST) begin
          r_paddle_step <= 1'b1;
          r_pad_cnt     <= '0;
        end else begin
          r_pad_cnt     <= r_pad_cnt + PAD_ONE;
        end
      end
    end
  end

  assign bus.ms_tick     = w_ms_tick;
  assign bus.ball_step   = r_ball_step;
  assign bus.paddle_step = r_paddle_step;
  assign bus.state       = r_state;
  assign bus.speed_level = r_level;

endmodule
